icb_acc_regfile: RTL

//  ICB slave that sits directly downstream of the core's ICB master port and consumes its

---
 rtl/icb_acc_regfile_if.sv | 40 ++++
 rtl/icb_acc_regfile.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/icb_acc_regfile_if.sv
// ICB command/response channel between the core master port and
// the accelerator register file.
interface icb_acc_regfile_if;
  logic        icb_cmd_valid;
  logic        icb_cmd_ready;
  logic        icb_cmd_read;
  logic [31:0] icb_cmd_addr;
  logic [31:0] icb_cmd_wdata;
  logic [3:0]  icb_cmd_wmask;
  logic        icb_rsp_valid;
  logic        icb_rsp_ready;
  logic [31:0] icb_rsp_rdata;
  logic        icb_rsp_err;

  modport master (
    output icb_cmd_valid,
    output icb_cmd_read,
    output icb_cmd_addr,
    output icb_cmd_wdata,
    output icb_cmd_wmask,
    output icb_rsp_ready,
    input  icb_cmd_ready,
    input  icb_rsp_valid,
    input  icb_rsp_rdata,
    input  icb_rsp_err
  );

  modport slave (
    input  icb_cmd_valid,
    input  icb_cmd_read,
    input  icb_cmd_addr,
    input  icb_cmd_wdata,
    input  icb_cmd_wmask,
    input  icb_rsp_ready,
    output icb_cmd_ready,
    output icb_rsp_valid,
    output icb_rsp_rdata,
    output icb_rsp_err
  );
endinterface

// File: rtl/icb_acc_regfile.sv
// ICB slave register file for the conv accelerator: control, status,
// layer configuration, start pulse and done interrupt.
module icb_acc_regfile #(
  parameter logic [31:0] BASE_ADDR   = 32'h1004_2000,
  parameter int          REGION_BITS = 12
) (
  input  logic               clk,
  input  logic               rst_,
  icb_acc_regfile_if.slave   icb,
  output logic               acc_start,
  input  logic               acc_busy,
  input  logic               acc_done,
  output logic [31:0]        ifm_base,
  output logic [31:0]        wgt_base,
  output logic [31:0]        ofm_base,
  output logic [31:0]        layer_cfg,
  output logic               irq
);

  localparam int RB = REGION_BITS;

  localparam logic [RB-1:0] OFF_CTRL = RB'(32'h00);
  localparam logic [RB-1:0] OFF_STAT = RB'(32'h04);
  localparam logic [RB-1:0] OFF_IFM  = RB'(32'h08);
  localparam logic [RB-1:0] OFF_WGT  = RB'(32'h0C);
  localparam logic [RB-1:0] OFF_OFM  = RB'(32'h10);
  localparam logic [RB-1:0] OFF_CFG  = RB'(32'h14);

  typedef enum logic {
    S_IDLE,
    S_RSP
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [31:0] ifm_q, ifm_d;
  logic [31:0] wgt_q, wgt_d;
  logic [31:0] ofm_q, ofm_d;
  logic [31:0] cfg_q, cfg_d;
  logic        irq_en_q, irq_en_d;
  logic        done_q, done_d;
  logic        start_q, start_d;
  logic        irq_q, irq_d;

  logic          cmd_ready;
  logic          cmd_hs;
  logic          rsp_hs;
  logic [RB-1:0] off;
  logic          hit;
  logic          aligned;
  logic          sel_ctrl, sel_stat;
  logic          sel_ifm, sel_wgt, sel_ofm, sel_cfg;
  logic          mapped;
  logic          is_cfg;
  logic          wr;
  logic          start_req;
  logic          lock_err;
  logic          acc_err;
  logic          we;
  logic          clr_done;
  logic [31:0]   rd_mux;

  function automatic logic [31:0] merge(
    input logic [31:0] old,
    input logic [31:0] wd,
    input logic [3:0]  m
  );
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) r[8*i +: 8] = wd[8*i +: 8];
    end
    return r;
  endfunction

  // One-entry response buffer: a new command may enter
  // in the same cycle the pending response drains.
  assign cmd_ready = (state_q == S_IDLE) | icb.icb_rsp_ready;
  assign cmd_hs    = icb.icb_cmd_valid & cmd_ready;
  assign rsp_hs    = (state_q == S_RSP) & icb.icb_rsp_ready;

  assign off      = icb.icb_cmd_addr[RB-1:0];
  assign hit      = icb.icb_cmd_addr[31:RB] == BASE_ADDR[31:RB];
  assign aligned  = icb.icb_cmd_addr[1:0] == 2'b00;
  assign sel_ctrl = off == OFF_CTRL;
  assign sel_stat = off == OFF_STAT;
  assign sel_ifm  = off == OFF_IFM;
  assign sel_wgt  = off == OFF_WGT;
  assign sel_ofm  = off == OFF_OFM;
  assign sel_cfg  = off == OFF_CFG;
  assign is_cfg   = sel_ifm | sel_wgt | sel_ofm | sel_cfg;
  assign mapped   = sel_ctrl | sel_stat | is_cfg;
  assign wr       = ~icb.icb_cmd_read;

  assign start_req = wr & sel_ctrl
                   & icb.icb_cmd_wmask[0]
                   & icb.icb_cmd_wdata[0];

  // Config is frozen and restart refused while the engine runs.
  assign lock_err = wr & (is_cfg | start_req) & acc_busy;
  assign acc_err  = ~hit | ~aligned | ~mapped | lock_err;
  assign we       = cmd_hs & wr & ~acc_err;

  assign clr_done = we & sel_stat
                  & icb.icb_cmd_wmask[0]
                  & icb.icb_cmd_wdata[1];

  always_comb begin
    rd_mux = 32'h0;
    unique case (1'b1)
      sel_ctrl: rd_mux = {30'h0, irq_en_q, 1'b0};
      sel_stat: rd_mux = {30'h0, done_q, acc_busy};
      sel_ifm:  rd_mux = ifm_q;
      sel_wgt:  rd_mux = wgt_q;
      sel_ofm:  rd_mux = ofm_q;
      sel_cfg:  rd_mux = cfg_q;
      default:  rd_mux = 32'h0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    ifm_d    = ifm_q;
    wgt_d    = wgt_q;
    ofm_d    = ofm_q;
    cfg_d    = cfg_q;
    irq_en_d = irq_en_q;
    start_d  = 1'b0;

    unique case (state_q)
      S_IDLE: if (cmd_hs) state_d = S_RSP;
      S_RSP:  if (rsp_hs && !cmd_hs) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (cmd_hs) begin
      err_d   = acc_err;
      rdata_d = (icb.icb_cmd_read && !acc_err) ? rd_mux : 32'h0;
    end

    if (we) begin
      if (sel_ctrl && icb.icb_cmd_wmask[0]) begin
        irq_en_d = icb.icb_cmd_wdata[1];
        start_d  = icb.icb_cmd_wdata[0];
      end
      if (sel_ifm)
        ifm_d = merge(ifm_q, icb.icb_cmd_wdata, icb.icb_cmd_wmask);
      if (sel_wgt)
        wgt_d = merge(wgt_q, icb.icb_cmd_wdata, icb.icb_cmd_wmask);
      if (sel_ofm)
        ofm_d = merge(ofm_q, icb.icb_cmd_wdata, icb.icb_cmd_wmask);
      if (sel_cfg)
        cfg_d = merge(cfg_q, icb.icb_cmd_wdata, icb.icb_cmd_wmask);
    end

    // A completion arriving with the W1C keeps the flag set.
    done_d = acc_done | (done_q & ~clr_done);
    irq_d  = done_q & irq_en_q;
  end

  always_ff @(posedge clk) begin
    if (rst_) begin
      state_q  <= S_IDLE;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
      ifm_q    <= 32'h0;
      wgt_q    <= 32'h0;
      ofm_q    <= 32'h0;
      cfg_q    <= 32'h0;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      start_q  <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      ifm_q    <= ifm_d;
      wgt_q    <= wgt_d;
      ofm_q    <= ofm_d;
      cfg_q    <= cfg_d;
      irq_en_q <= irq_en_d;
      done_q   <= done_d;
      start_q  <= start_d;
      irq_q    <= irq_d;
    end
  end

  assign icb.icb_cmd_ready = cmd_ready;
  assign icb.icb_rsp_valid = state_q == S_RSP;
  assign icb.icb_rsp_rdata = rdata_q;
  assign icb.icb_rsp_err   = err_q;

  assign acc_start = start_q;
  assign ifm_base  = ifm_q;
  assign wgt_base  = wgt_q;
  assign ofm_base  = ofm_q;
  assign layer_cfg = cfg_q;
  assign irq       = irq_q;

endmodule
